// File: rtl/zregfile_arbiter.sv
// zregfile_arbiter
//   Sole driver of the 4x8 CPU register file pins. Arbitrates between port A
//   (CPU core) and port B (debug/loader) round-robin and runs one transaction
//   at a time as IDLE -> ACCESS -> RESP (three cycles, never back-to-back).
// Ports
//   clk_i, rst_ni                   clock (rising edge), async active-low reset
//   a_req_i/a_we_i/a_sel_i/a_wdata_i port A request, held until a_gnt_o
//   a_gnt_o, a_rvalid_o, a_rdata_o   port A grant pulse, completion pulse, read data
//   b_*                              identical set for port B
//   rf_opcode_o/rf_sel_o/rf_in_o     register file OPCODE (1=write), REG_SEL, IN
//   rf_out_i                         register file OUT
//   busy_o                           high whenever not IDLE
module zregfile_arbiter #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [SEL_W-1:0]  a_sel_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_gnt_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [SEL_W-1:0]  b_sel_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_gnt_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              rf_opcode_o,
    output logic [SEL_W-1:0]  rf_sel_o,
    output logic [DATA_W-1:0] rf_in_o,
    input  logic [DATA_W-1:0] rf_out_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

    state_e              state_q, state_d;
    logic                ptr_q;      // 0: A has priority on a tie, 1: B
    logic                win_q;      // 0: A owns current transaction, 1: B
    logic                we_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;

    logic                any_req;
    logic                win_b;

    assign any_req = a_req_i | b_req_i;
    // A lone requester wins outright; on a tie the pointer decides.
    assign win_b   = b_req_i & (~a_req_i | ptr_q);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and read-data capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= 1'b0;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                win_q   <= win_b;
                ptr_q   <= ~win_b;
                we_q    <= win_b ? b_we_i    : a_we_i;
                sel_q   <= win_b ? b_sel_i   : a_sel_i;
                wdata_q <= win_b ? b_wdata_i : a_wdata_i;
            end
            if (state_q == ACCESS && !we_q) begin
                if (win_q) b_rdata_q <= rf_out_i;
                else       a_rdata_q <= rf_out_i;
            end
        end
    end

    // Outputs decoded from registered state; OPCODE is level-sensitive at the
    // register file, so it is only ever high for the single ACCESS cycle.
    always_comb begin
        a_gnt_o     = 1'b0;
        b_gnt_o     = 1'b0;
        a_rvalid_o  = 1'b0;
        b_rvalid_o  = 1'b0;
        rf_opcode_o = 1'b0;
        case (state_q)
            ACCESS: begin
                a_gnt_o     = ~win_q;
                b_gnt_o     = win_q;
                rf_opcode_o = we_q;
            end
            RESP: begin
                a_rvalid_o = ~win_q;
                b_rvalid_o = win_q;
            end
            default: ;
        endcase
    end

    assign rf_sel_o  = sel_q;
    assign rf_in_o   = wdata_q;
    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_zregfile_arbiter.sv
module tb_zregfile_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [1:0] a_sel = 0, b_sel = 0;
    logic [7:0] a_wd = 0, b_wd = 0;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, rf_opcode, busy;
    logic [7:0] a_rdata, b_rdata, rf_in, rf_out;
    logic [1:0] rf_sel;

    int checks = 0;
    int errors = 0;

    // Register file model: level-sensitive write observed at each rising edge.
    logic [7:0] regs [4];
    assign rf_out = regs[rf_sel];
    always @(posedge clk) if (rf_opcode) regs[rf_sel] <= rf_in;

    // Transaction-level reference model
    int         m_phase;   // 0 idle, 1 access, 2 resp
    int         m_win;     // 0 = A, 1 = B
    int         m_pri;     // port favoured on a tie
    logic       m_we;
    logic [1:0] m_sel;
    logic [7:0] m_wd;
    logic [7:0] exp_regs [4];
    logic [7:0] exp_rd [2];

    always #5 clk = ~clk;

    zregfile_arbiter #(.DATA_W(8), .SEL_W(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_sel_i(a_sel), .a_wdata_i(a_wd),
        .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_we_i(b_we), .b_sel_i(b_sel), .b_wdata_i(b_wd),
        .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
        .rf_opcode_o(rf_opcode), .rf_sel_o(rf_sel), .rf_in_o(rf_in),
        .rf_out_i(rf_out), .busy_o(busy)
    );

    task automatic model_reset();
        m_phase = 0; m_win = 0; m_pri = 0;
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    endtask

    // Advance one clock: apply the rules to the inputs present at the edge,
    // then return at the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        case (m_phase)
            0: if (a_req || b_req) begin
                if (a_req && b_req) m_win = m_pri;
                else                m_win = b_req ? 1 : 0;
                m_pri = 1 - m_win;
                m_we  = m_win ? b_we  : a_we;
                m_sel = m_win ? b_sel : a_sel;
                m_wd  = m_win ? b_wd  : a_wd;
                m_phase = 1;
            end
            1: begin
                if (m_we) exp_regs[m_sel] = m_wd;
                else      exp_rd[m_win]   = exp_regs[m_sel];
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        a_req = 0; b_req = 0;
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, rf_opcode, busy} !== 6'b0 ||
            a_rdata !== 8'h00 || b_rdata !== 8'h00 || rf_sel !== 2'd0 || rf_in !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b%b rv=%b%b op=%b busy=%b ard=%h brd=%h sel=%0d in=%h, want all 0",
                     a_gnt, b_gnt, a_rvalid, b_rvalid, rf_opcode, busy, a_rdata, b_rdata, rf_sel, rf_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_write_a();
        a_req = 1; a_we = 1; a_sel = 2; a_wd = 8'h5A;
        step();
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || rf_opcode !== 1'b1 || rf_sel !== 2'd2 ||
            rf_in !== 8'h5A || busy !== 1'b1) begin
            errors++;
            $display("FAIL write_access: gnt=%b/%b op=%b sel=%0d in=%h busy=%b want 1/0 1 2 5a 1",
                     a_gnt, b_gnt, rf_opcode, rf_sel, rf_in, busy);
        end
        a_req = 0; a_we = 0;
        step();
        checks++;
        if (a_rvalid !== 1'b1 || a_gnt !== 1'b0 || rf_opcode !== 1'b0) begin
            errors++;
            $display("FAIL write_resp: rvalid=%b gnt=%b op=%b want 1 0 0", a_rvalid, a_gnt, rf_opcode);
        end
        step();
        checks++;
        if (busy !== 1'b0 || a_rvalid !== 1'b0 || regs[2] !== 8'h5A) begin
            errors++;
            $display("FAIL write_done: busy=%b rvalid=%b R2=%h want 0 0 5a", busy, a_rvalid, regs[2]);
        end
    endtask

    task automatic test_read_a();
        a_req = 1; a_we = 0; a_sel = 2; a_wd = 8'h00;
        step();
        checks++;
        if (a_gnt !== 1'b1 || rf_opcode !== 1'b0) begin
            errors++; $display("FAIL read_access: gnt=%b op=%b want 1 0", a_gnt, rf_opcode);
        end
        a_req = 0;
        step();
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 8'h5A || rf_opcode !== 1'b0) begin
            errors++;
            $display("FAIL read_resp: rvalid=%b rdata=%h op=%b want 1 5a 0", a_rvalid, a_rdata, rf_opcode);
        end
        step();
    endtask

    task automatic test_both_alternate();
        logic [1:0] seq [$];
        apply_reset();
        a_req = 1; a_we = 0; a_sel = 1;
        b_req = 1; b_we = 0; b_sel = 2;
        step();
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            errors++; $display("FAIL tie_first: a_gnt=%b b_gnt=%b want 1 0", a_gnt, b_gnt);
        end
        a_req = 0;
        step(); step(); step();
        checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            errors++; $display("FAIL tie_second: a_gnt=%b b_gnt=%b want 0 1", a_gnt, b_gnt);
        end
        b_req = 0;
        step(); step();
        a_req = 1; b_req = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (a_gnt) seq.push_back(2'd1);
            if (b_gnt) seq.push_back(2'd2);
        end
        a_req = 0; b_req = 0;
        checks++;
        if (seq.size() != 4 || seq[0] != 2'd1 || seq[1] != 2'd2 || seq[2] != 2'd1 || seq[3] != 2'd2) begin
            errors++;
            $display("FAIL tie_alternate: %0d grants, first=%0d want 4 grants A,B,A,B (1,2,1,2)",
                     seq.size(), (seq.size() > 0) ? seq[0] : 2'd0);
        end
        step(); step(); step();
    endtask

    task automatic test_reset_during_write();
        logic [7:0] old3;
        old3 = regs[3];
        b_req = 1; b_we = 1; b_sel = 3; b_wd = 8'hFF;
        step();
        checks++;
        if (b_gnt !== 1'b1 || rf_opcode !== 1'b1) begin
            errors++; $display("FAIL rstwr_access: b_gnt=%b op=%b want 1 1", b_gnt, rf_opcode);
        end
        #1 rst_n = 1'b0;
        b_req = 0;
        #1;
        model_reset();
        checks++;
        if (rf_opcode !== 1'b0 || b_gnt !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstwr_abort: op=%b gnt=%b busy=%b want 0 0 0", rf_opcode, b_gnt, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b_rvalid !== 1'b0 || rf_opcode !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstwr_after: cyc=%0d rvalid=%b op=%b busy=%b want 0 0 0",
                         i, b_rvalid, rf_opcode, busy);
            end
        end
        checks++;
        if (regs[3] !== old3) begin
            errors++; $display("FAIL rstwr_nowrite: R3=%h want %h", regs[3], old3);
        end
    endtask

    task automatic test_withdraw();
        a_req = 1; a_we = 1; a_sel = 0; a_wd = 8'h33;
        #2 a_req = 0;
        step();
        checks++;
        if (busy !== 1'b0 || a_gnt !== 1'b0 || rf_opcode !== 1'b0) begin
            errors++;
            $display("FAIL withdraw: busy=%b gnt=%b op=%b want 0 0 0", busy, a_gnt, rf_opcode);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step();
            checks++;
            if (a_gnt !== (m_phase == 1 && m_win == 0) || b_gnt !== (m_phase == 1 && m_win == 1) ||
                a_rvalid !== (m_phase == 2 && m_win == 0) || b_rvalid !== (m_phase == 2 && m_win == 1) ||
                rf_opcode !== (m_phase == 1 && m_we) || busy !== (m_phase != 0) ||
                a_rdata !== exp_rd[0] || b_rdata !== exp_rd[1] ||
                (m_phase == 1 && (rf_sel !== m_sel || rf_in !== m_wd))) begin
                errors++;
                $display("FAIL random cyc=%0d: gnt=%b%b rv=%b%b op=%b busy=%b ard=%h brd=%h sel=%0d in=%h; want phase=%0d win=%0d we=%b ard=%h brd=%h sel=%0d in=%h",
                         c, a_gnt, b_gnt, a_rvalid, b_rvalid, rf_opcode, busy, a_rdata, b_rdata, rf_sel, rf_in,
                         m_phase, m_win, m_we, exp_rd[0], exp_rd[1], m_sel, m_wd);
            end
            // Requesters: drop on grant, otherwise start new requests at random.
            if (a_gnt) a_req = 0;
            if (b_gnt) b_req = 0;
            if (!a_req && ($urandom % 3 == 0)) begin
                a_req = 1; a_we = $urandom % 2; a_sel = $urandom % 4; a_wd = $urandom % 256;
            end
            if (!b_req && ($urandom % 3 == 0)) begin
                b_req = 1; b_we = $urandom % 2; b_sel = $urandom % 4; b_wd = $urandom % 256;
            end
        end
        a_req = 0; b_req = 0;
        step(); step(); step();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            regs[i] = 8'(8'h10 * i + 3);
            exp_regs[i] = 8'(8'h10 * i + 3);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        exp_regs[2] = 8'h5A;   // written by the directed A write below
        test_write_a();
        test_read_a();
        test_both_alternate();
        test_reset_during_write();
        test_withdraw();
        for (int i = 0; i < 4; i++) exp_regs[i] = regs[i];
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
